// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO that buffers a stream between a producer and a consumer in
// the same clock domain. Words are held in an inferred dual-ported array. They
// are written on accepted pushes and read through a registered port on
// accepted pops, so read latency is one cycle.
//
// Ports:
//   clk           single clock; all state changes on the rising edge
//   rst_n         asynchronous, active-low reset
//   wr_en, wdata  push request and push data
//   rd_en         pop request
//   rdata         popped word (registered, holds between pops)
//   rvalid        rdata was updated by a pop at the previous edge
//   full, empty   occupancy == DEPTH / occupancy == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..DEPTH
//   overflow      one-cycle pulse: push attempted while full
//   underflow     one-cycle pulse: pop attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds sized to the count width so the compares are width-matched.
  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

  // Pointers carry one extra wrap bit so that full and empty can be told apart
  // when the low address bits match.
  logic [AW:0]       wptr_reg;
  logic [AW:0]       rptr_reg;
  logic [WIDTH-1:0]  rdata_reg;
  logic              rvalid_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              push_ok;
  logic              pop_ok;
  logic [AW:0]       count_next;

  // Status decode straight from the pointer registers: no extra delay, and
  // only registered values feed the logic, so the flags change only at edges.
  always_comb begin
    count_next = wptr_reg - rptr_reg;
  end

  assign count        = count_next;
  assign empty        = (wptr_reg == rptr_reg);
  assign full         = (wptr_reg[AW] != rptr_reg[AW]) &&
                        (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign almost_full  = (count_next >= AF_THR);
  assign almost_empty = (count_next <= AE_THR);

  // Acceptance uses the flags from before the edge. For a push and a pop on
  // the same edge at full, the push is rejected even though the pop frees a
  // slot. At empty, the pop is rejected. There is no write-to-read bypass.
  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  // Storage has no reset so that it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      rdata_reg     <= '0;
      rvalid_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= wr_en & full;
      underflow_reg <= rd_en & empty;
      rvalid_reg    <= pop_ok;
      if (push_ok) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rptr_reg  <= rptr_reg + 1'b1;
        rdata_reg <= mem[rptr_reg[AW-1:0]];
      end
    end
  end

  assign rdata     = rdata_reg;
  assign rvalid    = rvalid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//
// Directed bench for sync_fifo with the default parameters (DEPTH=64,
// WIDTH=32). Inputs change 1 ns after each rising edge, and outputs are
// checked at that same point, after the edge has settled. Expected values are
// hand-derived constants and running counters that the bench keeps itself.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DEPTH = 64;
  localparam int WIDTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  int n_vec;
  int n_err;

  sync_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .AF_LEVEL (DEPTH - 4),
    .AE_LEVEL (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("%0t FAIL %s got=%0h want=%0h", $time, tag, obs, exp);
    end else begin
      $display("%0t ok   %s = %0h", $time, tag, obs);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rd_exp;
    int wd;

    n_vec = 0;
    n_err = 0;

    // ---------------- reset with both requests active ----------------
    rst_n = 1'b0;
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 32'h1234_5678;
    repeat (3) tick();
    chk("rst_empty",    empty, 1);
    chk("rst_aempty",   almost_empty, 1);
    chk("rst_count",    count, 0);
    chk("rst_rvalid",   rvalid, 0);
    chk("rst_rdata",    rdata, 0);
    chk("rst_full",     full, 0);
    chk("rst_afull",    almost_full, 0);
    chk("rst_ovf",      overflow, 0);
    chk("rst_udf",      underflow, 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("idle_count", count, 0);

    // ---------------- fill 0..63 ----------------
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1;
      wdata = i;
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_aempty", almost_empty, (i + 1) <= 4);
      chk("fill_afull", almost_full, (i + 1) >= 60);
      chk("fill_full", full, (i + 1) == 64);
    end
    wdata = 32'hDEAD;
    tick();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 64);
    wr_en = 1'b0;
    tick();
    chk("ovf_clear", overflow, 0);
    chk("ovf_count2", count, 64);

    // ---------------- drain 64 ----------------
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_rvalid", rvalid, 1);
      chk("drain_rdata", rdata, i);
      chk("drain_count", count, 63 - i);
      chk("drain_empty", empty, i == 63);
    end
    tick();
    chk("udf_pulse", underflow, 1);
    chk("udf_rvalid", rvalid, 0);
    chk("udf_rdata_hold", rdata, 63);
    rd_en = 1'b0;
    tick();
    chk("udf_clear", underflow, 0);

    // ---------------- steady state across pointer wrap ----------------
    wd = 1000;
    rd_exp = 1000;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wdata = wd;
      wd++;
      tick();
    end
    chk("pre_count", count, 10);
    rd_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wdata = wd;
      wd++;
      tick();
      chk("ss_count", count, 10);
      chk("ss_rvalid", rvalid, 1);
      chk("ss_rdata", rdata, rd_exp);
      rd_exp++;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ss_tail", rdata, rd_exp);
      rd_exp++;
    end
    rd_en = 1'b0;
    tick();
    chk("ss_empty", empty, 1);

    // ---------------- push+pop at full ----------------
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wdata = 32'h200 + i;
      tick();
    end
    chk("bf_full", full, 1);
    rd_en = 1'b1;
    wdata = 32'hBEEF;
    tick();
    chk("bf_rdata", rdata, 32'h200);
    chk("bf_rvalid", rvalid, 1);
    chk("bf_ovf", overflow, 1);
    chk("bf_count", count, 63);
    wr_en = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      chk("bf_drain", rdata, 32'h200 + i);
    end
    rd_en = 1'b0;
    tick();
    chk("bf_empty", empty, 1);

    // ---------------- push+pop at empty ----------------
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 32'h77;
    tick();
    chk("be_udf", underflow, 1);
    chk("be_rvalid", rvalid, 0);
    chk("be_count", count, 1);
    wr_en = 1'b0;
    tick();
    chk("be_rdata", rdata, 32'h77);
    chk("be_rvalid2", rvalid, 1);
    chk("be_count2", count, 0);
    rd_en = 1'b0;
    tick();

    // ---------------- async reset mid-stream ----------------
    wr_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wdata = 32'h300 + i;
      tick();
    end
    rd_en = 1'b1;
    wdata = 32'h400;
    tick();
    chk("ar_count_pre", count, 30);
    chk("ar_rvalid_pre", rvalid, 1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_rvalid", rvalid, 0);
    #2 rst_n = 1'b1;
    wr_en = 1'b1;
    wdata = 32'hA5;
    tick();
    chk("ar_push_count", count, 1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    chk("ar_rdata", rdata, 32'hA5);
    chk("ar_rvalid_post", rvalid, 1);
    rd_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock FIFO that owns the write and read pointers, status flags and storage for a buffered stream. It stores words in an internal dual-ported array, written on accepted pushes and read through a registered read port on accepted pops. The block is the control/access side that sits between a producer and a consumer in the same clock domain. It is the top-level FIFO for the synchronous path.

## Interface
Parameters:
- DEPTH, 64: number of entries. Must be a power of two and ≥ 4.
- WIDTH, 32: data word width.
- AF_LEVEL, DEPTH-4: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL.

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request.
- wdata  in  WIDTH  push data.
- rd_en  in  1  pop request.
- rdata  out  WIDTH  popped word, registered.
- rvalid  out  1  rdata updated by a pop at the previous edge.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: push attempted while full.
- underflow  out  1  one-cycle pulse: pop attempted while empty.

## Operation
- Pointers: wptr and rptr, each AW+1 bits. The MSB is the wrap bit.
  - empty when wptr == rptr.
  - full when the MSBs differ and the low AW bits are equal.
  - count = wptr − rptr, computed modulo 2^(AW+1).
- Push accepted = wr_en & !full, using the registered state at the edge.
  - On accept: mem[wptr[AW-1:0]] <= wdata, then wptr += 1.
- Pop accepted = rd_en & !empty.
  - On accept: rdata <= mem[rptr[AW-1:0]], rptr += 1, rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds its value.
- Simultaneous push and pop:
  - Mid-range: both are accepted and count is unchanged.
  - When full: the pop is accepted, the push is rejected and overflow pulses. count becomes DEPTH−1.
  - When empty: the push is accepted, the pop is rejected and underflow pulses. count becomes 1.
  - There is no write-to-read bypass.
- Rejected requests do not move pointers or change storage.
- overflow and underflow are registered. They go high for exactly one cycle after the edge where the rejected request was sampled.
- Pointer wrap-around is natural modulo 2^(AW+1). Data order is preserved across wraps.
- Status flags are decoded from the registered pointers and are glitch-free relative to clk.
- Reset (async, rst_n low), effective immediately and independent of clk:
  - wptr = rptr = 0, count = 0.
  - empty = 1, full = 0.
  - almost_empty = 1, almost_full = 0.
  - rvalid = 0, rdata = 0.
  - overflow = underflow = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored words and any pending rvalid.
  - The first edge after rst_n deasserts behaves as from empty.

## Timing
- Push at edge N: count, empty, almost_* and full reflect the new word after edge N.
- Pop at edge N: rdata and rvalid are valid during the cycle after edge N. Read latency is 1.
- Fastest push-to-data path: a push at edge N allows a pop at edge N+1, giving rdata after N+1.
- Sustained throughput: one push and one pop per cycle.
- Flag and count updates track pointer registers with zero additional delay.

## Test plan
- Reset: hold rst_n low for 3 cycles with wr_en=rd_en=1.
  - Required: empty=1, almost_empty=1, count=0, rvalid=0, rdata=0, full=0, no pulses.
- Fill (DEPTH=64): push 0..63 on consecutive cycles.
  - almost_empty deasserts after the 5th push.
  - almost_full asserts after the 60th push.
  - full and count=64 after the 64th push.
  - Push 0xDEAD while full: overflow pulses for 1 cycle and count stays 64.
- Drain: pop 64 times back-to-back.
  - rvalid=1 each following cycle, with rdata = 0..63 in order.
  - empty after the 64th pop.
  - Extra pop: underflow pulses, rvalid=0, rdata holds 63.
- Steady state with wrap: pre-fill 10 words, then push and pop every cycle for 200 cycles with incrementing data.
  - count stays 10 throughout.
  - Popped data is strictly sequential through pointer wrap.
- Boundaries:
  - At full with push+pop: pop returns the oldest word, overflow pulses, count=63.
  - At empty with push+pop: underflow pulses, rvalid=0, count=1. The next pop returns the pushed word.
- Async reset mid-stream at count=30, asserted between edges.
  - Required immediately: count=0, empty=1, rvalid=0.
  - After release: push 0xA5 then pop, giving rdata=0xA5 with rvalid.
